// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared definitions for the instruction-memory loader: state
//            encoding, word geometry and big-endian byte-lane extraction
//            (the fetch path uses the same lane order).
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WORD = 2'd1,
    ST_WRITE     = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  // Byte 0 is the most significant byte of the word (big-endian lane order).
  function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*(BYTES_PER_WORD - 1 - int'(idx)) +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Accepts 32-bit instruction words on a valid/ready stream and
//            writes each one as four big-endian bytes, one per cycle, into
//            the byte-wide instruction memory. Holds the CPU while loading.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MEM_BYTES = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W-1:0] wordCount,
  input  logic              inValid,
  output logic              inReady,
  input  logic [31:0]       inWord,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memData,
  output logic              busy,
  output logic              cpuHold,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] wordsWritten
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;        // next byte address to be written
  logic              r_wrap;       // pointer has wrapped during this load
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_words;
  logic [31:0]       r_word;
  logic [1:0]        r_idx;        // byte lane currently on the write port
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              r_overflow;
  logic              r_in_ready;
  logic              r_mem_we;
  logic              r_busy;
  logic              r_done;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              w_wrap_nxt;
  logic [ADDR_W-1:0] w_count_nxt;
  logic [ADDR_W-1:0] w_words_nxt;
  logic [31:0]       w_word_nxt;
  logic [1:0]        w_idx_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [7:0]        w_data_nxt;
  logic              w_ovf_nxt;
  logic              w_issue;      // a byte write is launched on the next cycle
  logic [7:0]        w_issue_byte;
  logic [ADDR_W-1:0] w_base_aligned;
  logic [ADDR_W-1:0] w_words_inc;

  assign w_base_aligned = baseAddr & ~ADDR_W'(3);
  assign w_words_inc    = r_words + 1'b1;

  // Next-state, datapath and byte-issue decisions
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_wrap_nxt   = r_wrap;
    w_count_nxt  = r_count;
    w_words_nxt  = r_words;
    w_word_nxt   = r_word;
    w_idx_nxt    = r_idx;
    w_addr_nxt   = r_mem_addr;
    w_data_nxt   = r_mem_data;
    w_ovf_nxt    = r_overflow;
    w_issue      = 1'b0;
    w_issue_byte = 8'h00;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_ptr_nxt   = w_base_aligned;
          w_wrap_nxt  = 1'b0;
          w_count_nxt = wordCount;
          w_words_nxt = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = (wordCount == '0) ? ST_DONE : ST_WAIT_WORD;
        end
      end
      ST_WAIT_WORD: begin
        if (inValid && r_in_ready) begin
          w_word_nxt   = inWord;
          w_idx_nxt    = 2'd0;
          w_issue      = 1'b1;
          w_issue_byte = be_byte(inWord, 2'd0);
          w_state_nxt  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (r_idx != LAST_BYTE_IDX) begin
          w_idx_nxt    = r_idx + 2'd1;
          w_issue      = 1'b1;
          w_issue_byte = be_byte(r_word, r_idx + 2'd1);
        end else begin
          w_words_nxt = w_words_inc;
          w_state_nxt = (w_words_inc == r_count) ? ST_DONE : ST_WAIT_WORD;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    // Overflow is flagged on the first write that lands after the wrap.
    if (w_issue) begin
      w_addr_nxt = r_ptr;
      w_data_nxt = w_issue_byte;
      w_ptr_nxt  = r_ptr + 1'b1;
      if (r_ptr == LAST_ADDR) w_wrap_nxt = 1'b1;
      if (r_wrap)             w_ovf_nxt  = 1'b1;
    end
  end

  // State and datapath registers; status flags registered from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_wrap     <= 1'b0;
      r_count    <= '0;
      r_words    <= '0;
      r_word     <= '0;
      r_idx      <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_overflow <= 1'b0;
      r_in_ready <= 1'b0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_wrap     <= w_wrap_nxt;
      r_count    <= w_count_nxt;
      r_words    <= w_words_nxt;
      r_word     <= w_word_nxt;
      r_idx      <= w_idx_nxt;
      r_mem_addr <= w_addr_nxt;
      r_mem_data <= w_data_nxt;
      r_overflow <= w_ovf_nxt;
      r_in_ready <= (w_state_nxt == ST_WAIT_WORD);
      r_mem_we   <= (w_state_nxt == ST_WRITE);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_DONE);
    end
  end

  assign inReady      = r_in_ready;
  assign memWe        = r_mem_we;
  assign memAddr      = r_mem_addr;
  assign memData      = r_mem_data;
  assign busy         = r_busy;
  assign cpuHold      = r_busy;
  assign done         = r_done;
  assign overflow     = r_overflow;
  assign wordsWritten = r_words;

endmodule
`default_nettype wire
